// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: function codes, FSM state
// encoding and decode helpers.
package alu_pkg;

    localparam logic [3:0] FN_AND   = 4'b0000;
    localparam logic [3:0] FN_OR    = 4'b0001;
    localparam logic [3:0] FN_ADD   = 4'b0010;
    localparam logic [3:0] FN_NOR   = 4'b0011;
    localparam logic [3:0] FN_XOR   = 4'b0100;
    localparam logic [3:0] FN_SUB   = 4'b0110;
    localparam logic [3:0] FN_MULLO = 4'b1010;
    localparam logic [3:0] FN_MULHI = 4'b1011;
    localparam logic [3:0] FN_DIVR  = 4'b1110;
    localparam logic [3:0] FN_DIVQ  = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic fn_is_muldiv(input logic [3:0] f);
        return (f == FN_MULLO) || (f == FN_MULHI) || (f == FN_DIVQ) || (f == FN_DIVR);
    endfunction

    function automatic logic fn_is_legal(input logic [3:0] f);
        return fn_is_muldiv(f) || (f == FN_AND) || (f == FN_OR) || (f == FN_ADD) ||
               (f == FN_NOR) || (f == FN_XOR) || (f == FN_SUB);
    endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Bit-serial unsigned multiplier (shift-add) and restoring divider sharing one
// 2*WIDTH shift register; one bit per clock, WIDTH steps after start.
module alu_iter_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] p_q, p_d, p_step;
    logic [WIDTH-1:0]   m_q, m_d, div_rem;
    logic [WIDTH:0]     mul_sum;
    logic               div_q, div_d, run_q, run_d, div_ge;
    logic [CW-1:0]      cnt_q, cnt_d;

    // mul: p = {accumulator, multiplier}; div: p = {remainder, quotient/dividend}
    always_comb begin
        mul_sum = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});
        div_ge  = p_q[2*WIDTH-1:WIDTH-1] >= {1'b0, m_q};
        div_rem = div_ge ? (p_q[2*WIDTH-2:WIDTH-1] - m_q) : p_q[2*WIDTH-2:WIDTH-1];
        p_step  = div_q ? {div_rem, p_q[WIDTH-2:0], div_ge} : {mul_sum, p_q[WIDTH-1:1]};
    end

    always_comb begin
        p_d   = p_q;
        m_d   = m_q;
        div_d = div_q;
        cnt_d = cnt_q;
        run_d = run_q;
        if (start) begin
            p_d   = {{WIDTH{1'b0}}, a};
            m_d   = b;
            div_d = op_div;
            cnt_d = CW'(WIDTH - 1);
            run_d = 1'b1;
        end else if (run_q) begin
            p_d = p_step;
            if (cnt_q == '0) begin
                run_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q   <= '0;
            m_q   <= '0;
            div_q <= 1'b0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            p_q   <= p_d;
            m_q   <= m_d;
            div_q <= div_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    // done marks the final step; hi/lo are the values that step produces,
    // so the caller registers the finished result on that same edge.
    assign done = run_q && (cnt_q == '0);
    assign hi   = p_step[2*WIDTH-1:WIDTH];
    assign lo   = p_step[WIDTH-1:0];

endmodule

// File: rtl/alu_multicycle.sv
// ALU with single-cycle add/sub/logic and bit-serial mul/div behind
// valid/ready handshakes; result, zero and illegal are registered.
//
//   state   | meaning
//   IDLE    | ready for a request; single-cycle ops finish on the accept edge
//   BUSY    | iterative mul/div running, one bit per clock
//   DONE    | result valid and held until out_ready
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter bit MUL_FULL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal,
    output logic             busy
);

    localparam int HALF = WIDTH / 2;

    state_e           state_q, state_d;
    logic [3:0]       funct_q, funct_d;
    logic [WIDTH-1:0] result_q, result_d, alu_res, md_a, md_b, md_hi, md_lo, md_res;
    logic             zero_q, zero_d, illegal_q, illegal_d;
    logic             accept, is_md, is_div, md_done;

    assign accept = (state_q == ST_IDLE) && in_valid;
    assign is_md  = fn_is_muldiv(funct);
    assign is_div = (funct == FN_DIVQ) || (funct == FN_DIVR);

    // Legacy 16x16 multiply: only the low halves of the operands take part.
    assign md_a = (!MUL_FULL && !is_div) ? {{(WIDTH-HALF){1'b0}}, a[HALF-1:0]} : a;
    assign md_b = (!MUL_FULL && !is_div) ? {{(WIDTH-HALF){1'b0}}, b[HALF-1:0]} : b;

    alu_iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (accept && is_md),
        .op_div (is_div),
        .a      (md_a),
        .b      (md_b),
        .done   (md_done),
        .hi     (md_hi),
        .lo     (md_lo)
    );

    assign md_res = ((funct_q == FN_MULHI) || (funct_q == FN_DIVR)) ? md_hi : md_lo;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid)  state_d = is_md ? ST_BUSY : ST_DONE;
            ST_BUSY: if (md_done)   state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            ST_IDLE: in_ready  = 1'b1;
            ST_BUSY: busy      = 1'b1;
            ST_DONE: out_valid = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        case (funct)
            FN_ADD:  alu_res = a + b;
            FN_SUB:  alu_res = a - b;
            FN_AND:  alu_res = a & b;
            FN_OR:   alu_res = a | b;
            FN_NOR:  alu_res = ~(a | b);
            FN_XOR:  alu_res = a ^ b;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        funct_d   = funct_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        if (accept) begin
            funct_d = funct;
            if (!is_md) begin
                result_d  = alu_res;
                zero_d    = (alu_res == '0);
                illegal_d = !fn_is_legal(funct);
            end
        end else if ((state_q == ST_BUSY) && md_done) begin
            result_d  = md_res;
            zero_d    = (md_res == '0);
            illegal_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            funct_q   <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            funct_q   <= funct_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

    assign result  = result_q;
    assign zero    = zero_q;
    assign illegal = illegal_q;

endmodule
